// File: rtl/sdp_fifo_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sdp_fifo_pkg : shared types and read-issue helper for the SDP FIFO controller
// Revision 1.0
// ---------------------------------------------------------------------------
package sdp_fifo_pkg;

  // Occupancy of the two-entry output buffer (0..2).
  typedef logic [1:0] ob_cnt_t;

  // A RAM read may be issued only if its data will have a buffer slot when it lands.
  function automatic logic can_issue(input ob_cnt_t ob_cnt,
                                     input logic    rd_pend,
                                     input logic    deq_fire);
    logic [2:0] committed;
    committed = {1'b0, ob_cnt} + {2'b00, rd_pend} - {2'b00, deq_fire};
    return (committed <= 3'd1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sdp_fifo_outbuf.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sdp_fifo_outbuf : two-entry first-word-fall-through buffer behind the RAM read port
// Revision 1.0
// ---------------------------------------------------------------------------
module sdp_fifo_outbuf
  import sdp_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  deq_ready,
  output logic                  deq_valid,
  output logic [DATA_WIDTH-1:0] deq_data,
  output ob_cnt_t               ob_cnt
);

  logic [DATA_WIDTH-1:0] ob0;
  logic [DATA_WIDTH-1:0] ob1;
  logic                  deq_fire;
  ob_cnt_t               slot;

  assign deq_valid = (ob_cnt != 2'd0);
  assign deq_fire  = deq_valid & deq_ready;
  assign deq_data  = ob0;
  assign slot      = ob_cnt - {1'b0, deq_fire};

  // ob0 only shifts when ob1 holds live data, so the head keeps its value once drained.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ob0    <= '0;
      ob1    <= '0;
      ob_cnt <= 2'd0;
    end else begin
      if (load && (slot == 2'd0)) begin
        ob0 <= load_data;
      end else if (deq_fire && (ob_cnt == 2'd2)) begin
        ob0 <= ob1;
      end
      if (load && (slot == 2'd1)) begin
        ob1 <= load_data;
      end
      ob_cnt <= ob_cnt + {1'b0, load} - {1'b0, deq_fire};
    end
  end

endmodule
`default_nettype wire

// File: rtl/sdp_fifo_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sdp_fifo_ctrl : FIFO controller driving an external BRAM_SDP with an FWFT dequeue port.
// Optional occupancy output enabled by defining SDP_FIFO_LEVEL_EN.  Revision 1.0
// ---------------------------------------------------------------------------
module sdp_fifo_ctrl
  import sdp_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enq_valid,
  output logic                  enq_ready,
  input  logic [DATA_WIDTH-1:0] enq_data,
  output logic                  deq_valid,
  input  logic                  deq_ready,
  output logic [DATA_WIDTH-1:0] deq_data,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_waddr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  output logic [ADDR_WIDTH-1:0] ram_raddr,
  input  logic [DATA_WIDTH-1:0] ram_q
`ifdef SDP_FIFO_LEVEL_EN
  ,
  output logic [ADDR_WIDTH+1:0] level
`endif
);

  localparam int PTR_W = ADDR_WIDTH + 1;
  localparam logic [PTR_W-1:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic [PTR_W-1:0] ram_cnt;
  logic             rd_pend;
  logic             enq_fire;
  logic             deq_fire;
  logic             issue;
  ob_cnt_t          ob_cnt;

  assign ram_cnt   = wptr - rptr;
  assign enq_ready = ~rst & (ram_cnt != DEPTH);
  assign enq_fire  = enq_valid & enq_ready;

  assign ram_we    = enq_fire;
  assign ram_waddr = wptr[ADDR_WIDTH-1:0];
  assign ram_wdata = enq_data;
  assign ram_raddr = rptr[ADDR_WIDTH-1:0];

  assign deq_fire  = deq_valid & deq_ready;
  // Registered pointers only: a read never targets the slot being written this cycle.
  assign issue     = (ram_cnt != '0) & can_issue(ob_cnt, rd_pend, deq_fire);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr    <= '0;
      rptr    <= '0;
      rd_pend <= 1'b0;
    end else begin
      if (enq_fire) begin
        wptr <= wptr + 1'b1;
      end
      if (issue) begin
        rptr <= rptr + 1'b1;
      end
      rd_pend <= issue;
    end
  end

  sdp_fifo_outbuf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_outbuf (
    .clk       (clk),
    .rst       (rst),
    .load      (rd_pend),
    .load_data (ram_q),
    .deq_ready (deq_ready),
    .deq_valid (deq_valid),
    .deq_data  (deq_data),
    .ob_cnt    (ob_cnt)
  );

`ifdef SDP_FIFO_LEVEL_EN
  assign level = (ADDR_WIDTH+2)'(ram_cnt) + (ADDR_WIDTH+2)'(rd_pend) + (ADDR_WIDTH+2)'(ob_cnt);
`endif

endmodule
`default_nettype wire

// File: tb/tb_sdp_fifo_ctrl.sv
`default_nettype none
// Bench for sdp_fifo_ctrl with a behavioural BRAM_SDP (DEPTH 4, capacity 6).
`timescale 1ns/1ps
module tb_sdp_fifo_ctrl;

  localparam int DW = 8;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          enq_valid;
  logic          enq_ready;
  logic [DW-1:0] enq_data;
  logic          deq_valid;
  logic          deq_ready;
  logic [DW-1:0] deq_data;
  logic          ram_we;
  logic [AW-1:0] ram_waddr;
  logic [DW-1:0] ram_wdata;
  logic [AW-1:0] ram_raddr;
  logic [DW-1:0] ram_q;
`ifdef SDP_FIFO_LEVEL_EN
  logic [AW+1:0] level;
`endif

  always #5 clk = ~clk;

  sdp_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .enq_valid (enq_valid),
    .enq_ready (enq_ready),
    .enq_data  (enq_data),
    .deq_valid (deq_valid),
    .deq_ready (deq_ready),
    .deq_data  (deq_data),
    .ram_we    (ram_we),
    .ram_waddr (ram_waddr),
    .ram_wdata (ram_wdata),
    .ram_raddr (ram_raddr),
    .ram_q     (ram_q)
`ifdef SDP_FIFO_LEVEL_EN
    ,
    .level     (level)
`endif
  );

  // BRAM_SDP: registered read, old data on collision.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (ram_we) mem[ram_waddr] <= ram_wdata;
    ram_q <= mem[ram_raddr];
  end

  int            n_checks = 0;
  int            n_pass   = 0;
  int            n_enq    = 0;
  logic [DW-1:0] sb [$];

  typedef struct {
    logic          ev;
    logic [DW-1:0] ed;
    logic          dr;
    logic          er;
    logic          dv;
    logic          cd;
    logic [DW-1:0] dd;
  } vec_t;

  vec_t tbl [0:18];

  function automatic vec_t mk(input logic ev, input logic [DW-1:0] ed, input logic dr,
                              input logic er, input logic dv, input logic cd,
                              input logic [DW-1:0] dd);
    vec_t v;
    v.ev = ev; v.ed = ed; v.dr = dr; v.er = er; v.dv = dv; v.cd = cd; v.dd = dd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " deq_valid"}, deq_valid, 0);
    chk({tag, " deq_data"},  deq_data,  0);
    chk({tag, " enq_ready"}, enq_ready, 0);
    chk({tag, " ram_we"},    ram_we,    0);
    chk({tag, " ram_waddr"}, ram_waddr, 0);
    chk({tag, " ram_raddr"}, ram_raddr, 0);
`ifdef SDP_FIFO_LEVEL_EN
    chk({tag, " level"},     level,     0);
`endif
  endtask

  // One cycle: drive after the falling edge, sample 1ns later, update the scoreboard.
  task automatic step(input logic ev, input logic [DW-1:0] ed, input logic dr, input bit use_sb);
    @(negedge clk);
    enq_valid = ev; enq_data = ed; deq_ready = dr;
    #1;
    if (use_sb) begin
`ifdef SDP_FIFO_LEVEL_EN
      chk("level_vs_model", level, sb.size());
`endif
      if (ram_we && (ram_waddr == ram_raddr)) chk("raddr_eq_waddr_only_when_ram_empty", sb.size() <= 2, 1);
      if (deq_valid && deq_ready) begin
        if (sb.size() == 0) begin
          n_checks++;
          $display("FAIL deq_spurious: got data %0h expected no valid", deq_data);
        end else begin
          chk("deq_data", deq_data, sb.pop_front());
        end
      end
      if (enq_valid && enq_ready) begin
        sb.push_back(enq_data);
        n_enq++;
      end
      if (sb.size() > 6) chk("capacity", sb.size(), 6);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    @(negedge clk);
    enq_valid = v.ev; enq_data = v.ed; deq_ready = v.dr;
    #1;
    chk($sformatf("vec%0d enq_ready", idx), enq_ready, v.er);
    chk($sformatf("vec%0d deq_valid", idx), deq_valid, v.dv);
    if (v.cd) chk($sformatf("vec%0d deq_data", idx), deq_data, v.dd);
  endtask

  initial begin
    logic [AW+1:0] lvl_ref;
    bit            found;
    lvl_ref = '0;

    // Single item latency
    tbl[0]  = mk(1, 8'hA5, 1, 1, 0, 0, 8'h00);
    tbl[1]  = mk(0, 8'h00, 1, 1, 0, 0, 8'h00);
    tbl[2]  = mk(0, 8'h00, 1, 1, 0, 0, 8'h00);
    tbl[3]  = mk(0, 8'h00, 1, 1, 1, 1, 8'hA5);
    tbl[4]  = mk(0, 8'h00, 1, 1, 0, 0, 8'h00);
    // Fill to capacity with consumer stalled, then drain
    tbl[5]  = mk(1, 8'h01, 0, 1, 0, 0, 8'h00);
    tbl[6]  = mk(1, 8'h02, 0, 1, 0, 0, 8'h00);
    tbl[7]  = mk(1, 8'h03, 0, 1, 0, 0, 8'h00);
    tbl[8]  = mk(1, 8'h04, 0, 1, 1, 1, 8'h01);
    tbl[9]  = mk(1, 8'h05, 0, 1, 1, 1, 8'h01);
    tbl[10] = mk(1, 8'h06, 0, 1, 1, 1, 8'h01);
    tbl[11] = mk(1, 8'h07, 0, 0, 1, 1, 8'h01);
    tbl[12] = mk(0, 8'h00, 1, 0, 1, 1, 8'h01);
    tbl[13] = mk(0, 8'h00, 1, 1, 1, 1, 8'h02);
    tbl[14] = mk(0, 8'h00, 1, 1, 1, 1, 8'h03);
    tbl[15] = mk(0, 8'h00, 1, 1, 1, 1, 8'h04);
    tbl[16] = mk(0, 8'h00, 1, 1, 1, 1, 8'h05);
    tbl[17] = mk(0, 8'h00, 1, 1, 1, 1, 8'h06);
    tbl[18] = mk(0, 8'h00, 1, 1, 0, 1, 8'h06);

    rst = 1'b1; enq_valid = 1'b1; enq_data = 8'h55; deq_ready = 1'b0;
    @(negedge clk); @(negedge clk);
    #1;
    chk_reset_outputs("reset");
    enq_valid = 1'b0;
    rst = 1'b0;

    for (int i = 0; i < 19; i++) run_vec(tbl[i], i);

    // Streaming: one enq and one deq per cycle once primed
    for (int i = 0; i < 43; i++) begin
      step(1, 8'(8'h10 + i), 1, 1);
      if (i >= 3) chk("stream_no_bubble", deq_valid, 1);
`ifdef SDP_FIFO_LEVEL_EN
      if (i == 5) lvl_ref = level;
      else if (i > 5) chk("stream_level_constant", level, lvl_ref);
`endif
    end
    for (int k = 0; k < 20 && sb.size() != 0; k++) step(0, 8'h00, 1, 1);
    chk("stream_drained", sb.size(), 0);

    // Full, one dequeue frees a slot the following cycle
    for (int i = 0; i < 10; i++) step(1, 8'(8'h40 + i), 0, 1);
    chk("full_enq_ready", enq_ready, 0);
    chk("full_count", sb.size(), 6);
    step(1, 8'h99, 1, 1);
    chk("full_deq_cycle_enq_ready", enq_ready, 0);
    step(1, 8'h77, 0, 1);
    chk("after_issue_enq_ready", enq_ready, 1);
    step(1, 8'h88, 0, 1);
    chk("refull_enq_ready", enq_ready, 0);
    for (int k = 0; k < 30 && sb.size() != 0; k++) step(0, 8'h00, 1, 1);
    chk("refill_drained", sb.size(), 0);

    // Random valid/ready, 1000 items
    n_enq = 0;
    for (int cyc = 0; cyc < 8000 && (n_enq < 1000 || sb.size() != 0); cyc++) begin
      step((n_enq < 1000) ? 1'($urandom % 2) : 1'b0, 8'($urandom), 1'($urandom % 2), 1);
    end
    chk("random_all_enqueued", n_enq >= 1000, 1);
    chk("random_drained", sb.size(), 0);

    // Asynchronous reset mid-burst
    for (int i = 0; i < 4; i++) step(1, 8'(8'hC0 + i), 0, 1);
    enq_valid = 1'b1; enq_data = 8'hEE; deq_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk_reset_outputs("midburst_reset");
    @(posedge clk);
    @(negedge clk);
    enq_valid = 1'b0;
    rst = 1'b0;
    sb.delete();
    step(1, 8'h3C, 1, 0);
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      step(0, 8'h00, 1, 0);
      if (deq_valid) begin
        chk("post_reset_first_data", deq_data, 8'h3C);
        found = 1'b1;
      end
    end
    if (!found) chk("post_reset_deq_valid_timeout", deq_valid, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
